// File: rtl/vga_dac_frontend_if.sv
// Pixel-side bundle between the pattern controller and the DAC front end:
// colour/timing/control inputs plus the aligned DAC and PMOD outputs.
interface vga_dac_if #(
  parameter int DAC_BITS = 8
);
  logic [DAC_BITS-1:0] r_in;
  logic [DAC_BITS-1:0] g_in;
  logic [DAC_BITS-1:0] b_in;
  logic                hsync_in;
  logic                vsync_in;
  logic                hblank_in;
  logic                vblank_in;
  logic                blank_en;
  logic                invert;

  logic [DAC_BITS-1:0] R;
  logic [DAC_BITS-1:0] G;
  logic [DAC_BITS-1:0] B;
  logic [7:0]          uo_out;
  logic                hblank_out;
  logic                vblank_out;

  modport master (
    output r_in, g_in, b_in, hsync_in, vsync_in, hblank_in, vblank_in,
           blank_en, invert,
    input  R, G, B, uo_out, hblank_out, vblank_out
  );

  modport slave (
    input  r_in, g_in, b_in, hsync_in, vsync_in, hblank_in, vblank_in,
           blank_en, invert,
    output R, G, B, uo_out, hblank_out, vblank_out
  );
endinterface

// File: rtl/vga_dac_frontend.sv
// Registered VGA-to-DAC front end: aligned colour/sync/blank pipeline with
// optional blanking and inversion, plus serially loaded, vblank-synchronised bias words.
module vga_dac_frontend #(
  parameter int                   DAC_BITS    = 8,
  parameter int                   BIAS_BITS   = 3,
  parameter int                   PIPE_STAGES = 2,
  parameter logic [BIAS_BITS-1:0] BIAS_RESET  = BIAS_BITS'(4)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_dac_if.slave             pix,
  input  logic                 cfg_en,
  input  logic                 cfg_bit,
  input  logic                 cfg_commit,
  output logic [BIAS_BITS-1:0] Rbias,
  output logic [BIAS_BITS-1:0] Gbias,
  output logic [BIAS_BITS-1:0] Bbias,
  output logic                 cfg_pending
);

  // Pipeline word layout: {hsync, vsync, hblank, vblank, r, g, b}
  localparam int W    = 3*DAC_BITS + 4;
  localparam int B_LO = 0;
  localparam int G_LO = DAC_BITS;
  localparam int R_LO = 2*DAC_BITS;
  localparam int VB   = 3*DAC_BITS;
  localparam int HB   = 3*DAC_BITS + 1;
  localparam int VS   = 3*DAC_BITS + 2;
  localparam int HS   = 3*DAC_BITS + 3;
  localparam int SW   = 3*BIAS_BITS;

  logic                           blank;
  logic [W-1:0]                   in_word;
  logic [PIPE_STAGES-1:0][W-1:0]  pipe_reg;
  logic [W-1:0]                   last;
  logic [W-1:0]                   last_next;
  logic                           inv_reg;
  logic                           vblank_rise;

  logic [SW-1:0]                  shift_reg;
  logic [SW-1:0]                  staged_reg;
  logic [SW-1:0]                  live_reg;
  logic                           pending_reg;

  always_comb begin
    blank   = pix.blank_en & (pix.hblank_in | pix.vblank_in);
    in_word = {pix.hsync_in, pix.vsync_in, pix.hblank_in, pix.vblank_in,
               blank ? '0 : pix.r_in,
               blank ? '0 : pix.g_in,
               blank ? '0 : pix.b_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_reg <= '0;
      inv_reg  <= 1'b0;
    end else begin
      pipe_reg[0] <= in_word;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
      inv_reg <= pix.invert;
    end
  end

  assign last = pipe_reg[PIPE_STAGES-1];

  // Value the final stage takes at the next edge; used to spot the vblank_out rise.
  generate
    if (PIPE_STAGES == 1) begin : g_single
      assign last_next = in_word;
    end else begin : g_multi
      assign last_next = pipe_reg[PIPE_STAGES-2];
    end
  endgenerate

  assign vblank_rise = last_next[VB] & ~last[VB];

  // Codes are stored uninverted so the PMOD sees post-blank, pre-invert bits.
  assign pix.R          = last[R_LO +: DAC_BITS] ^ {DAC_BITS{inv_reg}};
  assign pix.G          = last[G_LO +: DAC_BITS] ^ {DAC_BITS{inv_reg}};
  assign pix.B          = last[B_LO +: DAC_BITS] ^ {DAC_BITS{inv_reg}};
  assign pix.hblank_out = last[HB];
  assign pix.vblank_out = last[VB];
  assign pix.uo_out     = {last[HS],
                           last[B_LO+DAC_BITS-2], last[G_LO+DAC_BITS-2], last[R_LO+DAC_BITS-2],
                           last[VS],
                           last[B_LO+DAC_BITS-1], last[G_LO+DAC_BITS-1], last[R_LO+DAC_BITS-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      staged_reg  <= '0;
      live_reg    <= {3{BIAS_RESET}};
      pending_reg <= 1'b0;
    end else begin
      if (cfg_en) begin
        shift_reg <= {shift_reg[SW-2:0], cfg_bit};
      end
      if (vblank_rise && pending_reg) begin
        live_reg <= staged_reg;
      end
      // A commit on the transfer edge re-arms with the new snapshot.
      if (cfg_commit) begin
        staged_reg  <= shift_reg;
        pending_reg <= 1'b1;
      end else if (vblank_rise) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign Rbias       = live_reg[0 +: BIAS_BITS];
  assign Gbias       = live_reg[BIAS_BITS +: BIAS_BITS];
  assign Bbias       = live_reg[2*BIAS_BITS +: BIAS_BITS];
  assign cfg_pending = pending_reg;

endmodule

// File: tb/tb_vga_dac_frontend.sv
// Directed bench for vga_dac_frontend in two configurations:
// (8,3,2) and (4,2,1); both DUTs share stimulus, one is checked per suite.
module tb_vga_dac_frontend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] r_d, g_d, b_d;
  logic       hs, vs, hb, vb, blank_en, invert;
  logic       cfg_en, cfg_bit, cfg_commit;

  vga_dac_if #(.DAC_BITS(8)) if_a();
  vga_dac_if #(.DAC_BITS(4)) if_b();

  assign if_a.r_in = r_d;       assign if_b.r_in = r_d[7:4];
  assign if_a.g_in = g_d;       assign if_b.g_in = g_d[7:4];
  assign if_a.b_in = b_d;       assign if_b.b_in = b_d[7:4];
  assign if_a.hsync_in  = hs;   assign if_b.hsync_in  = hs;
  assign if_a.vsync_in  = vs;   assign if_b.vsync_in  = vs;
  assign if_a.hblank_in = hb;   assign if_b.hblank_in = hb;
  assign if_a.vblank_in = vb;   assign if_b.vblank_in = vb;
  assign if_a.blank_en  = blank_en; assign if_b.blank_en = blank_en;
  assign if_a.invert    = invert;   assign if_b.invert   = invert;

  logic [2:0] rbias_a, gbias_a, bbias_a;
  logic [1:0] rbias_b, gbias_b, bbias_b;
  logic       pend_a, pend_b;

  vga_dac_frontend #(.DAC_BITS(8), .BIAS_BITS(3), .PIPE_STAGES(2), .BIAS_RESET(3'b100)) dut_a (
    .clk(clk), .rst_n(rst_n), .pix(if_a),
    .cfg_en(cfg_en), .cfg_bit(cfg_bit), .cfg_commit(cfg_commit),
    .Rbias(rbias_a), .Gbias(gbias_a), .Bbias(bbias_a), .cfg_pending(pend_a)
  );

  vga_dac_frontend #(.DAC_BITS(4), .BIAS_BITS(2), .PIPE_STAGES(1), .BIAS_RESET(2'b10)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix(if_b),
    .cfg_en(cfg_en), .cfg_bit(cfg_bit), .cfg_commit(cfg_commit),
    .Rbias(rbias_b), .Gbias(gbias_b), .Bbias(bbias_b), .cfg_pending(pend_b)
  );

  int         sel;
  logic [7:0] r_o, g_o, uo_o;
  logic       hbo, vbo, pend_o;
  logic [2:0] rb_o, gb_o, bb_o;

  always_comb begin
    if (sel == 0) begin
      r_o = if_a.R; g_o = if_a.G; uo_o = if_a.uo_out;
      hbo = if_a.hblank_out; vbo = if_a.vblank_out; pend_o = pend_a;
      rb_o = rbias_a; gb_o = gbias_a; bb_o = bbias_a;
    end else begin
      r_o = {4'b0, if_b.R}; g_o = {4'b0, if_b.G}; uo_o = if_b.uo_out;
      hbo = if_b.hblank_out; vbo = if_b.vblank_out; pend_o = pend_b;
      rb_o = {1'b0, rbias_b}; gb_o = {1'b0, gbias_b}; bb_o = {1'b0, bbias_b};
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cfg%0d: got %0h want %0h", tag, sel, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bias(input string tag, input int eb, input int eg, input int er);
    check_eq({tag, "_B"}, 32'(bb_o), 32'(eb));
    check_eq({tag, "_G"}, 32'(gb_o), 32'(eg));
    check_eq({tag, "_R"}, 32'(rb_o), 32'(er));
  endtask

  task automatic shift_word(input logic [8:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      cfg_en  = 1'b1;
      cfg_bit = w[i];
      tick();
    end
    cfg_en  = 1'b0;
    cfg_bit = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic run_suite(input int which);
    int         lat, nb, rst_b, gmax;
    logic [8:0] w1, w2, w3, w4;
    bit         inblank;
    sel   = which;
    lat   = (which == 0) ? 2 : 1;
    nb    = (which == 0) ? 9 : 6;
    rst_b = (which == 0) ? 4 : 2;
    gmax  = (which == 0) ? 8'hFF : 8'h0F;
    w1    = (which == 0) ? 9'b001_010_111 : 9'b000_01_10_11;
    w2    = (which == 0) ? 9'b110_101_011 : 9'b000_00_01_10;
    w3    = (which == 0) ? 9'b011_100_001 : 9'b000_10_00_01;
    w4    = (which == 0) ? 9'b111_111_111 : 9'b000_11_11_11;

    // Reset with every input at its default.
    r_d = 0; g_d = 0; b_d = 0; hs = 0; vs = 0; hb = 0; vb = 0;
    blank_en = 0; invert = 0; cfg_en = 0; cfg_bit = 0; cfg_commit = 0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_R", 32'(r_o), 0);
    check_eq("rst_uo", 32'(uo_o), 0);
    check_eq("rst_pending", 32'(pend_o), 0);
    check_eq("rst_vblank_out", 32'(vbo), 0);
    expect_bias("rst_bias", rst_b, rst_b, rst_b);

    // Latency and PMOD mapping.
    r_d = 8'hA5; hs = 1'b1;
    if (lat > 1) begin
      tick();
      check_eq("lat_R_early", 32'(r_o), 0);
      repeat (lat - 1) tick();
    end else begin
      tick();
    end
    check_eq("lat_R", 32'(r_o), (which == 0) ? 8'hA5 : 8'h0A);
    check_eq("lat_uo", 32'(uo_o), 8'h81);
    hs = 1'b0; r_d = 8'h00;

    // Blank window, then the same window inverted.
    for (int pass = 0; pass < 2; pass++) begin
      blank_en = 1'b1; g_d = 8'hFF; invert = 1'b0;
      repeat (lat + 1) tick();
      hb = 1'b1;
      invert = (pass == 1);
      for (int k = 1; k <= 7; k++) begin
        tick();
        hb = (k < 3);
        inblank = (k >= lat) && (k < lat + 3);
        if (pass == 0) begin
          check_eq($sformatf("blank_G_k%0d", k), 32'(g_o), inblank ? 0 : gmax);
          check_eq($sformatf("blank_hbo_k%0d", k), 32'(hbo), 32'(inblank));
        end else begin
          check_eq($sformatf("inv_G_k%0d", k), 32'(g_o), inblank ? gmax : 0);
        end
      end
    end
    invert = 1'b0; blank_en = 1'b0; g_d = 8'h00;
    repeat (lat + 1) tick();

    // Load and commit, transfer on vblank rise.
    shift_word(w1, nb);
    check_eq("pre_commit_pending", 32'(pend_o), 0);
    commit();
    check_eq("commit_pending", 32'(pend_o), 1);
    vb = 1'b1;
    repeat (lat - 1) tick();
    expect_bias("pre_xfer", rst_b, rst_b, rst_b);
    tick();
    check_eq("xfer_vbo", 32'(vbo), 1);
    check_eq("xfer_pending", 32'(pend_o), 0);
    if (which == 0) expect_bias("xfer1", 1, 2, 7);
    else            expect_bias("xfer1", 1, 2, 3);
    vb = 1'b0;
    repeat (3) tick();

    // Commit exactly on the transfer edge.
    shift_word(w2, nb);
    commit();
    shift_word(w3, nb);
    vb = 1'b1;
    repeat (lat - 1) tick();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check_eq("race_vbo", 32'(vbo), 1);
    check_eq("race_pending", 32'(pend_o), 1);
    if (which == 0) expect_bias("race_xfer", 6, 5, 3);
    else            expect_bias("race_xfer", 0, 1, 2);
    vb = 1'b0;
    repeat (3) tick();
    vb = 1'b1;
    repeat (lat) tick();
    check_eq("race2_pending", 32'(pend_o), 0);
    if (which == 0) expect_bias("race2_xfer", 3, 4, 1);
    else            expect_bias("race2_xfer", 2, 0, 1);

    // Asynchronous reset mid-shift with a commit pending.
    vb = 1'b0; r_d = 8'hA5;
    repeat (lat + 1) tick();
    vb = 1'b1;
    repeat (lat) tick();
    check_eq("pre_rst_uo", 32'(uo_o), 8'h01);
    shift_word(w4, nb);
    commit();
    cfg_en = 1'b1; cfg_bit = 1'b1;
    tick(); tick();
    check_eq("pre_rst_pending", 32'(pend_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_R", 32'(r_o), 0);
    check_eq("async_uo", 32'(uo_o), 0);
    check_eq("async_vbo", 32'(vbo), 0);
    check_eq("async_pending", 32'(pend_o), 0);
    expect_bias("async_bias", rst_b, rst_b, rst_b);
    cfg_en = 1'b0; cfg_bit = 1'b0;
    tick();
    rst_n = 1'b1;
    vb = 1'b0;
    repeat (2) tick();
    vb = 1'b1;
    repeat (lat + 1) tick();
    check_eq("post_rst_vbo", 32'(vbo), 1);
    expect_bias("post_rst_bias", rst_b, rst_b, rst_b);
    vb = 1'b0; r_d = 8'h00;
    repeat (3) tick();
  endtask

  initial begin
    sel = 0;
    rst_n = 1'b0;
    r_d = 0; g_d = 0; b_d = 0; hs = 0; vs = 0; hb = 0; vb = 0;
    blank_en = 0; invert = 0; cfg_en = 0; cfg_bit = 0; cfg_commit = 0;
    run_suite(0);
    run_suite(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
